// File: rtl/ahbl_master_pkg.sv
// Shared AHB-Lite encodings and initiator FSM state type.
// Used by ahbl_master, ahbl_lane_steer and the bus interface.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        RESP,
        DRAIN
    } state_t;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/ahbl_master_if.sv
// Request/response port plus AHB-Lite bus signals of the initiator.
// Modport master is the initiator side, slave the environment side.
interface ahbl_master_if;
    import ahbl_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HRESP;

    modport master (
        input  req_valid, req_write, req_addr,
        input  req_size, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output HADDR, HTRANS, HSIZE, HWRITE, HWDATA,
        input  HREADY, HRDATA, HRESP
    );

    modport slave (
        output req_valid, req_write, req_addr,
        output req_size, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  HADDR, HTRANS, HSIZE, HWRITE, HWDATA,
        output HREADY, HRDATA, HRESP
    );

endinterface

// File: rtl/ahbl_master_lane_steer.sv
// Byte-lane handling: write replication, read extraction and
// zero-extension, and the size/address alignment check.
module ahbl_lane_steer
    import ahbl_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [2:0]  size,
    input  logic [31:0] wdata,
    input  logic [31:0] hrdata,
    output logic [31:0] hwdata,
    output logic [31:0] rdata,
    output logic        aligned
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        rd_byte = 8'h00;
        unique case (addr)
            2'd0: rd_byte = hrdata[7:0];
            2'd1: rd_byte = hrdata[15:8];
            2'd2: rd_byte = hrdata[23:16];
            2'd3: rd_byte = hrdata[31:24];
        endcase
        rd_half = addr[1] ? hrdata[31:16]
                          : hrdata[15:0];
    end

    always_comb begin
        hwdata  = '0;
        rdata   = '0;
        aligned = 1'b0;
        case (size)
            HSIZE_BYTE: begin
                hwdata  = {4{wdata[7:0]}};
                rdata   = {24'h0, rd_byte};
                aligned = 1'b1;
            end
            HSIZE_HALF: begin
                hwdata  = {2{wdata[15:0]}};
                rdata   = {16'h0, rd_half};
                aligned = ~addr[0];
            end
            HSIZE_WORD: begin
                hwdata  = wdata;
                rdata   = hrdata;
                aligned = (addr == 2'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ahbl_master.sv
// Single-outstanding AHB-Lite initiator: one NONSEQ per request.
// Optional data-phase stall timeout: AHBL_MASTER_TIMEOUT_EN.
module ahbl_master
    import ahbl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    ahbl_master_if.master bus
);

    state_t      state_q;
    state_t      state_d;
    req_t        req_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic        accept;
    logic [31:0] hwdata_rep;
    logic [31:0] rdata_ext;
    logic        aligned;
    logic        tmo_hit;
    logic        tmo_q;

    ahbl_lane_steer u_steer (
        .addr    (req_q.addr[1:0]),
        .size    (req_q.size),
        .wdata   (req_q.wdata),
        .hrdata  (bus.HRDATA),
        .hwdata  (hwdata_rep),
        .rdata   (rdata_ext),
        .aligned (aligned)
    );

    assign accept = bus.req_valid
                  && state_q == IDLE;

`ifdef AHBL_MASTER_TIMEOUT_EN
    localparam int unsigned CW =
        $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] tmo_cnt_q;

    assign tmo_hit = state_q == DATA
                   && !bus.HREADY
                   && tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge HCLK) begin
        if (!HRESETn || state_q != DATA)
            tmo_cnt_q <= '0;
        else if (!bus.HREADY)
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) tmo_q <= 1'b0;
        else          tmo_q <= tmo_hit;
    end
`else
    logic unused_tmo;
    assign unused_tmo = |TIMEOUT_CYCLES;
    assign tmo_hit    = 1'b0;
    assign tmo_q      = 1'b0;
`endif

    always_ff @(posedge HCLK) begin
        if (!HRESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:
                if (bus.req_valid) state_d = ADDR;
            ADDR:
                if (!aligned)        state_d = RESP;
                else if (bus.HREADY) state_d = DATA;
            DATA:
                if (bus.HREADY || tmo_hit)
                    state_d = RESP;
`ifdef AHBL_MASTER_TIMEOUT_EN
            RESP:
                state_d = tmo_q ? DRAIN : IDLE;
            DRAIN:
                if (bus.HREADY) state_d = IDLE;
`else
            RESP:
                state_d = IDLE;
`endif
            default:
                state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            req_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (accept)
                req_q <= '{write: bus.req_write,
                           addr:  bus.req_addr,
                           size:  bus.req_size,
                           wdata: bus.req_wdata};
            if (state_q == ADDR && !aligned) begin
                rsp_err_q   <= 1'b1;
                rsp_rdata_q <= '0;
            end
            if (state_q == DATA && bus.HREADY) begin
                rsp_err_q <= bus.HRESP == HRESP_ERROR;
                rsp_rdata_q <=
                    (bus.HRESP == HRESP_ERROR || req_q.write)
                    ? '0 : rdata_ext;
            end
            if (tmo_hit) begin
                rsp_err_q   <= 1'b1;
                rsp_rdata_q <= '0;
            end
        end
    end

    always_comb begin
        bus.req_ready = HRESETn && state_q == IDLE;
        bus.HTRANS    = HTRANS_IDLE;
        if (state_q == ADDR && aligned)
            bus.HTRANS = HTRANS_NONSEQ;
        bus.HADDR     = req_q.addr;
        bus.HSIZE     = req_q.size;
        bus.HWRITE    = req_q.write;
        bus.HWDATA    = '0;
        if (state_q == DATA && req_q.write)
            bus.HWDATA = hwdata_rep;
        bus.rsp_valid = state_q == RESP;
        bus.rsp_rdata = rsp_rdata_q;
        bus.rsp_err   = rsp_err_q;
    end

endmodule

// File: tb/tb_ahbl_master.sv
// Directed bench for ahbl_master with a response scoreboard.
// Build with AHBL_MASTER_TIMEOUT_EN to add the stall-timeout case.
module tb_ahbl_master;
    import ahbl_pkg::*;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    int   tests = 0;
    int   fails = 0;
    logic [32:0] sb_q[$];

    always #5 HCLK = ~HCLK;

    ahbl_master_if bus ();

    ahbl_master #(.TIMEOUT_CYCLES(8)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    task automatic xfer(
        input string       tag,
        input logic        w,
        input logic [31:0] a,
        input logic [2:0]  sz,
        input logic [31:0] wd,
        input logic [31:0] rd,
        input int          waits,
        input logic        err,
        input logic [31:0] exp_hwdata,
        input logic [31:0] exp_rdata,
        input logic        exp_err,
        input int          exp_lat,
        input logic        exp_bus);
        int          dj;
        bit          got;
        bit          nonseq;
        logic [32:0] e;
        @(negedge HCLK);
        chk({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_size  = sz;
        bus.req_wdata = wd;
        bus.HREADY    = 1'b1;
        bus.HRESP     = 1'b0;
        sb_q.push_back({exp_err, exp_rdata});
        dj     = -1;
        got    = 1'b0;
        nonseq = 1'b0;
        for (int c = 1; c <= 64 && !got; c++) begin
            @(negedge HCLK);
            bus.req_valid = 1'b0;
            if (bus.rsp_valid) begin
                got = 1'b1;
                bus.HRESP = 1'b0;
                chk({tag, ".lat"}, 32'(c), 32'(exp_lat));
                if (sb_q.size() == 0) begin
                    chk({tag, ".sb_empty"}, 32'd0, 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    chk({tag, ".rdata"}, bus.rsp_rdata, e[31:0]);
                    chk({tag, ".err"}, 32'(bus.rsp_err),
                        32'(e[32]));
                end
            end else if (bus.HTRANS == HTRANS_NONSEQ) begin
                nonseq = 1'b1;
                chk({tag, ".haddr"}, bus.HADDR, a);
                chk({tag, ".hsize"}, 32'(bus.HSIZE), 32'(sz));
                chk({tag, ".hwrite"}, 32'(bus.HWRITE), 32'(w));
                dj = 0;
                bus.HREADY = 1'b1;
            end else if (dj >= 0) begin
                if (w)
                    chk({tag, ".hwdata"}, bus.HWDATA,
                        exp_hwdata);
                bus.HREADY = (dj == waits);
                bus.HRDATA = rd;
                bus.HRESP  = err && (dj >= waits - 1);
                dj++;
            end
        end
        if (!got) begin
            tests++;
            fails++;
            $error("FAIL %s.rsp_timeout: observed=none required=rsp_valid",
                   tag);
            void'(sb_q.pop_front());
        end
        chk({tag, ".nonseq"}, 32'(nonseq), 32'(exp_bus));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=hang required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_size  = '0;
        bus.req_wdata = '0;
        bus.HREADY    = 1'b1;
        bus.HRDATA    = '0;
        bus.HRESP     = 1'b0;

        repeat (3) @(negedge HCLK);
        chk("rst.ready", 32'(bus.req_ready), 32'd0);
        chk("rst.htrans", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
        chk("rst.haddr", bus.HADDR, 32'd0);
        chk("rst.hsize", 32'(bus.HSIZE), 32'd0);
        chk("rst.hwrite", 32'(bus.HWRITE), 32'd0);
        chk("rst.hwdata", bus.HWDATA, 32'd0);
        chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst.rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst.rsp_err", 32'(bus.rsp_err), 32'd0);
        HRESETn = 1'b1;

        xfer("wr_word", 1'b1, 32'h4000_0004, HSIZE_WORD,
             32'hCAFE_F00D, 32'h0, 0, 1'b0,
             32'hCAFE_F00D, 32'h0, 1'b0, 3, 1'b1);
        xfer("rd_byte", 1'b0, 32'h4000_0003, HSIZE_BYTE,
             32'h0, 32'h1122_3344, 0, 1'b0,
             32'h0, 32'h0000_0011, 1'b0, 3, 1'b1);
        xfer("wr_half_ws", 1'b1, 32'h4000_0002, HSIZE_HALF,
             32'h0000_0022, 32'h0, 3, 1'b0,
             32'h0022_0022, 32'h0, 1'b0, 6, 1'b1);
        xfer("rd_word_mis", 1'b0, 32'h4000_0006, HSIZE_WORD,
             32'h0, 32'hFFFF_FFFF, 0, 1'b0,
             32'h0, 32'h0, 1'b1, 2, 1'b0);
        xfer("rd_hresp", 1'b0, 32'h4000_0008, HSIZE_WORD,
             32'h0, 32'hDEAD_BEEF, 1, 1'b1,
             32'h0, 32'h0, 1'b1, 4, 1'b1);
        xfer("rd_word", 1'b0, 32'h4000_000C, HSIZE_WORD,
             32'h0, 32'hA5A5_5A5A, 0, 1'b0,
             32'h0, 32'hA5A5_5A5A, 1'b0, 3, 1'b1);
        xfer("rd_half_hi", 1'b0, 32'h4000_0012, HSIZE_HALF,
             32'h0, 32'h1122_3344, 2, 1'b0,
             32'h0, 32'h0000_1122, 1'b0, 5, 1'b1);
        xfer("wr_byte", 1'b1, 32'h4000_0001, HSIZE_BYTE,
             32'h1234_56AB, 32'h0, 0, 1'b0,
             32'hABAB_ABAB, 32'h0, 1'b0, 3, 1'b1);
        xfer("wr_half_mis", 1'b1, 32'h4000_0001, HSIZE_HALF,
             32'h0000_BEEF, 32'h0, 0, 1'b0,
             32'h0, 32'h0, 1'b1, 2, 1'b0);
        xfer("bad_size", 1'b0, 32'h4000_0000, 3'd3,
             32'h0, 32'h0, 0, 1'b0,
             32'h0, 32'h0, 1'b1, 2, 1'b0);
        xfer("wr_werr", 1'b1, 32'h4000_0020, HSIZE_WORD,
             32'h0BAD_F00D, 32'h5555_5555, 1, 1'b1,
             32'h0BAD_F00D, 32'h0, 1'b1, 4, 1'b1);

        @(negedge HCLK);
        chk("mid.ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h4000_0010;
        bus.req_size  = HSIZE_WORD;
        @(negedge HCLK);
        bus.req_valid = 1'b0;
        chk("mid.nonseq", 32'(bus.HTRANS),
            32'(HTRANS_NONSEQ));
        @(negedge HCLK);
        bus.HREADY = 1'b0;
        HRESETn    = 1'b0;
        @(negedge HCLK);
        chk("mid.htrans", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
        chk("mid.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid.ready_rst", 32'(bus.req_ready), 32'd0);
        HRESETn    = 1'b1;
        bus.HREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK);
            chk("mid.no_rsp", 32'(bus.rsp_valid), 32'd0);
            chk("mid.idle", 32'(bus.HTRANS),
                32'(HTRANS_IDLE));
        end
        chk("mid.ready_after", 32'(bus.req_ready), 32'd1);

`ifdef AHBL_MASTER_TIMEOUT_EN
        xfer("tmo", 1'b0, 32'h4000_0030, HSIZE_WORD,
             32'h0, 32'h1234_5678, 20, 1'b0,
             32'h0, 32'h0, 1'b1, 10, 1'b1);
        for (int c = 11; c <= 21; c++) begin
            @(negedge HCLK);
            chk("tmo.drain_ready", 32'(bus.req_ready), 32'd0);
            chk("tmo.drain_rsp", 32'(bus.rsp_valid), 32'd0);
            chk("tmo.drain_idle", 32'(bus.HTRANS),
                32'(HTRANS_IDLE));
        end
        @(negedge HCLK);
        chk("tmo.ready_hi", 32'(bus.req_ready), 32'd0);
        bus.HREADY = 1'b1;
        @(negedge HCLK);
        chk("tmo.ready_back", 32'(bus.req_ready), 32'd1);
`endif

        chk("sb.empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed",
                 tests, fails);
        $finish;
    end

endmodule
